// File: rtl/alu_slice_sequencer.sv
// Sequencer that feeds a 2-bit ALU slice one digit per cycle (LSB first) and assembles a WIDTH-bit result.
// Optional synchronous flush port enabled by defining ALU_SEQ_FLUSH_EN.
module alu_slice_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH/2) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef ALU_SEQ_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    input  logic             in_cin,
    output logic [1:0]       sl_a,
    output logic [1:0]       sl_b,
    output logic [3:0]       sl_op,
    output logic             sl_cin,
    input  logic [1:0]       sl_f,
    input  logic             sl_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_f,
    output logic             out_cout,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH/2 - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH+1:0]   w_cat;
    logic [WIDTH-1:0]   w_res_nxt;
    logic               w_flush;
    logic               w_accept;
    logic               w_step;
    logic               w_last;

`ifdef ALU_SEQ_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // New digit enters at the top; after N shifts digit 0 sits at bit 0.
    assign w_cat     = {sl_f, r_res};
    assign w_res_nxt = w_cat[WIDTH+1:2];
    assign w_last    = (r_cnt == LAST);

    // Next-state and per-cycle action decode.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        if (w_flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        w_accept    = 1'b1;
                        w_state_nxt = RUN;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                RUN: begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State register and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            in_ready  <= (w_state_nxt == IDLE);
            out_valid <= (w_state_nxt == DONE);
        end
    end

    // Operand shifting, slice drive, carry ripple and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_res    <= {WIDTH{1'b0}};
            sl_a     <= 2'b00;
            sl_b     <= 2'b00;
            sl_op    <= 4'h0;
            sl_cin   <= 1'b0;
            out_f    <= {WIDTH{1'b0}};
            out_cout <= 1'b0;
            out_zero <= 1'b0;
        end else if (w_flush) begin
            r_cnt  <= {CNT_W{1'b0}};
            sl_a   <= 2'b00;
            sl_b   <= 2'b00;
            sl_cin <= 1'b0;
        end else if (w_accept) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_a    <= in_a >> 2'd2;
            r_b    <= in_b >> 2'd2;
            sl_a   <= in_a[1:0];
            sl_b   <= in_b[1:0];
            sl_op  <= in_op;
            sl_cin <= in_cin;
        end else if (w_step) begin
            r_res <= w_res_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                out_f    <= w_res_nxt;
                out_cout <= sl_cout;
                out_zero <= (w_res_nxt == {WIDTH{1'b0}});
                sl_a     <= 2'b00;
                sl_b     <= 2'b00;
                sl_cin   <= 1'b0;
            end else begin
                r_a    <= r_a >> 2'd2;
                r_b    <= r_b >> 2'd2;
                sl_a   <= r_a[1:0];
                sl_b   <= r_b[1:0];
                sl_cin <= sl_cout;
            end
        end
    end

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Directed self-checking bench for alu_slice_sequencer (WIDTH=8) with a behavioural 2-bit slice.
module tb_alu_slice_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [3:0] in_op;
    logic       in_cin;
    logic [1:0] sl_a;
    logic [1:0] sl_b;
    logic [3:0] sl_op;
    logic       sl_cin;
    logic [1:0] sl_f;
    logic       sl_cout;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_f;
    logic       out_cout;
    logic       out_zero;
`ifdef ALU_SEQ_FLUSH_EN
    logic       flush;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] seq_a   [4];
    logic       seq_cin [4];
    logic       seq_vld [4];

    alu_slice_sequencer #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef ALU_SEQ_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_cin    (in_cin),
        .sl_a      (sl_a),
        .sl_b      (sl_b),
        .sl_op     (sl_op),
        .sl_cin    (sl_cin),
        .sl_f      (sl_f),
        .sl_cout   (sl_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_f     (out_f),
        .out_cout  (out_cout),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slice model: op 0 add, op 1 AND
    always_comb begin
        sl_f    = 2'b00;
        sl_cout = 1'b0;
        case (sl_op)
            4'h0: {sl_cout, sl_f} = {1'b0, sl_a} + {1'b0, sl_b} + {2'b00, sl_cin};
            4'h1: sl_f = sl_a & sl_b;
            default: sl_f = 2'b00;
        endcase
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input logic cin);
        for (int i = 0; i < 20 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL issue_ready_timeout: in_ready=%b want 1", in_ready);
        end
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_cin = cin;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_digits();
        for (int k = 0; k < 4; k++) begin
            seq_a[k]   = sl_a;
            seq_cin[k] = sl_cin;
            seq_vld[k] = out_valid;
            @(posedge clk); #1;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00;
        in_op = 4'h0; in_cin = 1'b0; out_ready = 1'b0;
`ifdef ALU_SEQ_FLUSH_EN
        flush = 1'b0;
`endif
        #12;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_vec++; if ({out_f, out_cout, out_zero} !== 10'h000) begin n_err++; $display("FAIL rst_out: got %h want 000", {out_f, out_cout, out_zero}); end
        n_vec++; if ({sl_a, sl_b, sl_op, sl_cin} !== 9'h000) begin n_err++; $display("FAIL rst_slice: got %h want 000", {sl_a, sl_b, sl_op, sl_cin}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        issue(8'h5A, 8'h3C, 4'h0, 1'b0);
        run_digits();
        n_vec++; if ({seq_a[0], seq_a[1], seq_a[2], seq_a[3]} !== 8'b10_10_01_01) begin n_err++; $display("FAIL add_sl_a_seq: got %b want 10100101", {seq_a[0], seq_a[1], seq_a[2], seq_a[3]}); end
        n_vec++; if ({seq_vld[0], seq_vld[1], seq_vld[2], seq_vld[3]} !== 4'b0000) begin n_err++; $display("FAIL add_early_valid: got %b want 0000", {seq_vld[0], seq_vld[1], seq_vld[2], seq_vld[3]}); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_latency: out_valid=%b want 1", out_valid); end
        n_vec++; if (out_f !== 8'h96) begin n_err++; $display("FAIL add_f: got %h want 96", out_f); end
        n_vec++; if ({out_cout, out_zero} !== 2'b00) begin n_err++; $display("FAIL add_flags: got %b want 00", {out_cout, out_zero}); end
        n_vec++; if ({sl_a, sl_b, sl_cin} !== 5'b0) begin n_err++; $display("FAIL add_slice_idle: got %b want 00000", {sl_a, sl_b, sl_cin}); end
        handshake();
        n_vec++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL add_handshake: got %b want 01", {out_valid, in_ready}); end
    endtask

    task automatic test_carry();
        issue(8'hFF, 8'h01, 4'h0, 1'b0);
        run_digits();
        n_vec++; if ({seq_cin[0], seq_cin[1], seq_cin[2], seq_cin[3]} !== 4'b0111) begin n_err++; $display("FAIL carry_cin_seq: got %b want 0111", {seq_cin[0], seq_cin[1], seq_cin[2], seq_cin[3]}); end
        n_vec++; if ({out_valid, out_f, out_cout, out_zero} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin n_err++; $display("FAIL carry_result: got %h want %h", {out_valid, out_f, out_cout, out_zero}, {1'b1, 8'h00, 1'b1, 1'b1}); end
        handshake();
    endtask

    task automatic test_and();
        issue(8'hF0, 8'h0F, 4'h1, 1'b0);
        run_digits();
        n_vec++; if ({out_valid, out_f, out_cout, out_zero} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin n_err++; $display("FAIL and_zero: got %h want %h", {out_valid, out_f, out_cout, out_zero}, {1'b1, 8'h00, 1'b0, 1'b1}); end
        n_vec++; if (sl_op !== 4'h1) begin n_err++; $display("FAIL and_sl_op_hold: got %h want 1", sl_op); end
        handshake();
        issue(8'hA5, 8'hFF, 4'h1, 1'b0);
        run_digits();
        n_vec++; if ({out_valid, out_f, out_cout, out_zero} !== {1'b1, 8'hA5, 1'b0, 1'b0}) begin n_err++; $display("FAIL and_nonzero: got %h want %h", {out_valid, out_f, out_cout, out_zero}, {1'b1, 8'hA5, 1'b0, 1'b0}); end
        handshake();
    endtask

    task automatic test_backpressure();
        issue(8'h12, 8'h34, 4'h0, 1'b0);
        run_digits();
        in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_op = 4'h1; in_cin = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if ({out_valid, in_ready, out_f, out_cout, out_zero, sl_a} !== {1'b1, 1'b0, 8'h46, 1'b0, 1'b0, 2'b00}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got %h want %h", i, {out_valid, in_ready, out_f, out_cout, out_zero, sl_a}, {1'b1, 1'b0, 8'h46, 1'b0, 1'b0, 2'b00});
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        handshake();
        n_vec++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL bp_release: got %b want 01", {out_valid, in_ready}); end
        @(posedge clk); #1;
        n_vec++; if ({in_ready, sl_a, sl_op} !== {1'b1, 2'b00, 4'h0}) begin n_err++; $display("FAIL bp_not_accepted: got %h want %h", {in_ready, sl_a, sl_op}, {1'b1, 2'b00, 4'h0}); end
    endtask

    task automatic test_reset_mid_run();
        issue(8'hE4, 8'hFF, 4'h0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_vec++; if (sl_a !== 2'd2) begin n_err++; $display("FAIL rmid_digit2: got %0d want 2", sl_a); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if ({in_ready, out_valid, out_f, out_cout, out_zero} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin n_err++; $display("FAIL rmid_out: got %h want %h", {in_ready, out_valid, out_f, out_cout, out_zero}, {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}); end
        n_vec++; if ({sl_a, sl_b, sl_op, sl_cin} !== 9'h000) begin n_err++; $display("FAIL rmid_slice: got %h want 000", {sl_a, sl_b, sl_op, sl_cin}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(8'h01, 8'h01, 4'h0, 1'b1);
        run_digits();
        n_vec++; if ({out_valid, out_f, out_cout, out_zero} !== {1'b1, 8'h03, 1'b0, 1'b0}) begin n_err++; $display("FAIL rmid_after: got %h want %h", {out_valid, out_f, out_cout, out_zero}, {1'b1, 8'h03, 1'b0, 1'b0}); end
        handshake();
    endtask

`ifdef ALU_SEQ_FLUSH_EN
    task automatic test_flush();
        logic seen;
        issue(8'h77, 8'h11, 4'h0, 1'b0);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_vec++; if ({in_ready, out_valid, sl_a, sl_cin} !== {1'b1, 1'b0, 2'b00, 1'b0}) begin n_err++; $display("FAIL flush_idle: got %b want %b", {in_ready, out_valid, sl_a, sl_cin}, {1'b1, 1'b0, 2'b00, 1'b0}); end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen = seen | out_valid;
            @(posedge clk); #1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_no_valid: got %b want 0", seen); end
        issue(8'h10, 8'h20, 4'h0, 1'b0);
        run_digits();
        n_vec++; if ({out_valid, out_f} !== {1'b1, 8'h30}) begin n_err++; $display("FAIL flush_next: got %h want %h", {out_valid, out_f}, {1'b1, 8'h30}); end
        handshake();
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_and();
        test_backpressure();
        test_reset_mid_run();
`ifdef ALU_SEQ_FLUSH_EN
        test_flush();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_slice_sequencer.md
Name: alu_slice_sequencer

Overview:
Sequential front/back stage for the combinational 2-bit ALU slice. It accepts a wide operand pair and a function code over a valid/ready handshake. It then drives the slice one 2-bit digit per cycle, LSB first, rippling the slice carry through a register. It assembles the WIDTH-bit result, carry-out and zero flag and presents them on a valid/ready output port.

Parameters:
WIDTH, 8, operand/result width in bits; even, >= 2; digit count N = WIDTH/2
CNT_W, clog2(WIDTH/2)+1, width of the internal digit counter

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  stage can accept a request
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_op  input  4  slice function select, passed to the slice unmodified
in_cin  input  1  carry into digit 0
sl_a  output  2  current A digit to slice
sl_b  output  2  current B digit to slice
sl_op  output  4  function select to slice
sl_cin  output  1  carry into current digit
sl_f  input  2  slice result digit (combinational from sl_*)
sl_cout  input  1  slice carry out
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_f  output  WIDTH  assembled result
out_cout  output  1  sl_cout of digit N-1
out_zero  output  1  1 when out_f == 0

Behaviour:
- Reset values (async, rst_n low):
  - state=IDLE, in_ready=1, out_valid=0
  - out_f/out_cout/out_zero=0
  - sl_a/sl_b/sl_op/sl_cin=0
  - counter=0
  - A/B/op/carry registers=0
- A reset asserted mid-operation discards the operation; there is no partial output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch in_a, in_b, in_op and in_cin, clear counter, go to RUN.
- RUN:
  - in_ready=0.
  - sl_a=A[2k+1:2k] and sl_b=B[2k+1:2k], k=counter; all driven from registers (no comb path from in_*).
  - sl_op=latched op.
  - sl_cin=latched in_cin for k=0; otherwise the registered sl_cout of digit k-1.
  - Each edge: store sl_f into result bits [2k+1:2k], register sl_cout, increment k.
  - On the edge where k==N-1: go to DONE, set out_valid=1, out_cout=sl_cout, out_zero=(complete result==0).
  - RUN lasts exactly N cycles.
  - Latency: out_valid rises N edges after the accepting edge.
- DONE:
  - out_f/out_cout/out_zero hold stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready, clear out_valid and go to IDLE. in_ready returns to 1 in the following cycle (one bubble; no overlap).
- sl_a/sl_b/sl_cin read 0 outside RUN. sl_op holds the last op.
- in_* changes while in_ready=0 are ignored.
- out_ready is ignored when out_valid=0.
- WIDTH=2: RUN is a single cycle.

Optional Feature:
Macro ALU_SEQ_FLUSH_EN.
- Defined:
  - Adds port flush (input, 1), synchronous, highest priority.
  - When high on an edge in any state: go to IDLE, clear out_valid, counter and carry register.
  - Captured result bits are not guaranteed to be cleared.
  - A request with in_valid high in the same cycle as flush is not accepted.
- Undefined: the port is absent; no flush logic exists.

Test Plan:
Bench slice model: op 4'h0 is add, {sl_cout,sl_f}=sl_a+sl_b+sl_cin; op 4'h1 is AND, sl_f=sl_a&sl_b, sl_cout=0.
- WIDTH=8, a=0x5A, b=0x3C, cin=0, op=0 -> out_f=0x96, out_cout=0, out_zero=0; out_valid exactly 4 edges after acceptance; sl_a sequence 2,2,1,1.
- a=0xFF, b=0x01, cin=0, op=0 -> out_f=0x00, out_cout=1, out_zero=1; sl_cin sequence 0,1,1,1.
- a=0xF0, b=0x0F, op=1 -> out_f=0x00, out_zero=1, out_cout=0. Then a=0xA5, b=0xFF, op=1 -> 0xA5, out_zero=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0; in_valid with new operands is not accepted. Release -> handshake completes, in_ready=1 one cycle later.
- Pull rst_n low at RUN digit 2 -> all outputs 0 immediately. After release, a new request a=0x01, b=0x01, cin=1, op=0 -> out_f=0x03.
- With ALU_SEQ_FLUSH_EN: flush during RUN digit 1 -> IDLE next cycle, out_valid never rises. The next request a=0x10, b=0x20, op=0 -> 0x30.
